// File: rtl/avalon_led_sequencer.sv
// Avalon-MM LED animation sequencer: config slave register file plus a master
// that issues single-cycle writes of each new frame to the LED PIO.
module avalon_led_sequencer #(
  parameter int unsigned          WIDTH          = 8,
  parameter int unsigned          DIV_WIDTH      = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_PERIOD = 24'd50_000_00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  led_address,
  output logic        led_chipselect,
  output logic        led_write_n,
  output logic [31:0] led_writedata
);

  localparam int unsigned StepW = WIDTH + 1;

  localparam logic [2:0] ModeRotl   = 3'd1;
  localparam logic [2:0] ModeRotr   = 3'd2;
  localparam logic [2:0] ModeBounce = 3'd3;
  localparam logic [2:0] ModeBlink  = 3'd4;
  localparam logic [2:0] ModeCount  = 3'd5;

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [WIDTH-1:0]     frame_q, frame_d;
  logic [WIDTH-1:0]     pattern_q, pattern_d;
  logic [2:0]           mode_q, mode_d;
  logic                 en_q, en_d;
  logic                 wrap_q, wrap_d;
  logic                 led_cs_q, led_cs_d;
  logic                 led_wn_q, led_wn_d;
  logic [31:0]          led_data_q, led_data_d;

  logic                 wr, ctrl_wr, tick;
  logic [DIV_WIDTH-1:0] presc_last;
  logic [StepW-1:0]     step_nxt;
  logic [WIDTH-1:0]     frame_nxt;
  logic                 unused_wd;

  assign unused_wd = ^writedata;

  // Index of the final step in one wrap cycle of each mode.
  function automatic logic [StepW-1:0] last_step(input logic [2:0] mode);
    case (mode)
      ModeRotl, ModeRotr: last_step = StepW'(WIDTH - 1);
      ModeBounce:         last_step = StepW'(2 * WIDTH - 3);
      ModeBlink:          last_step = StepW'(1);
      ModeCount:          last_step = StepW'((1 << WIDTH) - 1);
      default:            last_step = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] step_frame(input logic [2:0]       mode,
                                                  input logic [StepW-1:0] step,
                                                  input logic [WIDTH-1:0] pattern,
                                                  input logic [WIDTH-1:0] prev);
    logic [StepW-1:0] pos;
    pos        = (step < StepW'(WIDTH)) ? step : StepW'(2 * WIDTH - 2) - step;
    step_frame = pattern;
    case (mode)
      ModeRotl:   step_frame = {prev[WIDTH-2:0], prev[WIDTH-1]};
      ModeRotr:   step_frame = {prev[0], prev[WIDTH-1:1]};
      ModeBounce: step_frame = WIDTH'(1) << pos;
      ModeBlink:  step_frame = step[0] ? '0 : pattern;
      ModeCount:  step_frame = step[WIDTH-1:0];
      default:    ;
    endcase
  endfunction

  assign wr         = chipselect & ~write_n;
  assign ctrl_wr    = wr && (address == 2'd0);
  // PERIOD of 0 behaves as 1, so the compare value saturates at 0.
  assign presc_last = (period_q == '0) ? '0 : period_q - DIV_WIDTH'(1);
  assign tick       = (state_q == StRun) && (presc_q >= presc_last);
  assign step_nxt   = (step_q == last_step(mode_q)) ? '0 : step_q + StepW'(1);
  assign frame_nxt  = step_frame(mode_q, step_nxt, pattern_q, frame_q);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    period_d   = period_q;
    step_d     = step_q;
    frame_d    = frame_q;
    pattern_d  = pattern_q;
    mode_d     = mode_q;
    en_d       = en_q;
    wrap_d     = wrap_q;
    led_cs_d   = 1'b0;
    led_wn_d   = 1'b1;
    led_data_d = led_data_q;

    if (ctrl_wr) begin
      en_d   = writedata[0];
      mode_d = writedata[3:1];
    end
    if (wr && address == 2'd1) period_d = writedata[DIV_WIDTH-1:0];
    if (wr && address == 2'd2) pattern_d = writedata[WIDTH-1:0];
    if (wr && address == 2'd3 && writedata[1]) wrap_d = 1'b0;

    if (ctrl_wr && writedata[0]) begin
      state_d = StRun;
      presc_d = '0;
      step_d  = '0;
      case (writedata[3:1])
        ModeBounce: frame_d = WIDTH'(1);
        ModeCount:  frame_d = '0;
        default:    frame_d = pattern_q;
      endcase
      led_cs_d   = 1'b1;
      led_wn_d   = 1'b0;
      led_data_d = 32'(frame_d);
    end else begin
      if (state_q == StRun) presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
      // A tick coinciding with a disable still delivers its strobe.
      if (tick) begin
        step_d     = step_nxt;
        frame_d    = frame_nxt;
        led_cs_d   = 1'b1;
        led_wn_d   = 1'b0;
        led_data_d = 32'(frame_nxt);
        if (step_nxt == '0) wrap_d = 1'b1;
      end
      if (ctrl_wr) begin
        state_d = StIdle;
        presc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      period_q   <= DEFAULT_PERIOD;
      step_q     <= '0;
      frame_q    <= '0;
      pattern_q  <= WIDTH'(1);
      mode_q     <= '0;
      en_q       <= 1'b0;
      wrap_q     <= 1'b0;
      led_cs_q   <= 1'b0;
      led_wn_q   <= 1'b1;
      led_data_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      step_q     <= step_d;
      frame_q    <= frame_d;
      pattern_q  <= pattern_d;
      mode_q     <= mode_d;
      en_q       <= en_d;
      wrap_q     <= wrap_d;
      led_cs_q   <= led_cs_d;
      led_wn_q   <= led_wn_d;
      led_data_q <= led_data_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[3:0] = {mode_q, en_q};
      2'd1:    readdata[DIV_WIDTH-1:0] = period_q;
      2'd2:    readdata[WIDTH-1:0] = pattern_q;
      default: begin
        readdata[0]         = (state_q == StRun);
        readdata[1]         = wrap_q;
        readdata[8 +: WIDTH] = frame_q;
      end
    endcase
  end

  assign led_address    = 2'b00;
  assign led_chipselect = led_cs_q;
  assign led_write_n    = led_wn_q;
  assign led_writedata  = led_data_q;

endmodule

// File: doc/avalon_led_sequencer.md
# avalon_led_sequencer

Avalon-MM controller that animates the 8-bit LED PIO without CPU involvement. The CPU configures mode, step period and base pattern through a small slave register file. The block then runs a frame sequencer and issues single-cycle Avalon write transfers to the LED PIO slave, one per step. It sits between the Nios II data master (config side) and the LED PIO `s1` slave (master side).

## Interface
- `WIDTH`, 8: LED count, and width of frame, pattern and `led_writedata` payload.
- `DIV_WIDTH`, 24: prescaler width and width of the PERIOD register.
- `DEFAULT_PERIOD`, 24'd50_000_00: PERIOD reset value, in clock cycles per step.

- `clk`, in, 1: system clock; everything is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `address`, in, 2: config register select.
- `chipselect`, in, 1: config slave select.
- `write_n`, in, 1: config write strobe, active-low.
- `writedata`, in, 32: config write data.
- `readdata`, out, 32: config read data, combinational from `address`, read latency 0.
- `led_address`, out, 2: PIO address; constant 0.
- `led_chipselect`, out, 1: PIO select, registered.
- `led_write_n`, out, 1: PIO write strobe, active-low, registered.
- `led_writedata`, out, 32: PIO data, `{zero-extend, frame}`, registered.

## Operation
- A config write occurs on any edge with `chipselect & ~write_n`. Unused bits read 0.
- Register map:
  - 0 CTRL: [0] enable, [3:1] mode. Reset 0.
  - 1 PERIOD: [DIV_WIDTH-1:0]. Reset `DEFAULT_PERIOD`. The effective period P = max(PERIOD, 1).
  - 2 PATTERN: [WIDTH-1:0]. Reset 8'h01.
  - 3 STATUS: [0] running (RO), [1] wrap flag (sticky, write 1 to clear), [15:8] current frame (RO).
- FSM states:
  - IDLE: prescaler held at 0 and no strobes. Goes to RUN on a CTRL write with enable=1.
  - RUN: goes to IDLE on a CTRL write with enable=0.
- Restart: any CTRL write with enable=1 loads the step-0 frame, clears the prescaler and schedules one strobe. This applies whether the block is in IDLE or RUN, and whether or not the mode changed.
- Modes, giving the step-0 frame, then the next-frame rule, then when wrap is flagged:
  - 0 STATIC: step 0 = PATTERN; next = PATTERN re-read each step; wrap every step.
  - 1 ROTL: step 0 = PATTERN; next = rotate left by 1; wrap after WIDTH steps.
  - 2 ROTR: step 0 = PATTERN; next = rotate right by 1; wrap after WIDTH steps.
  - 3 BOUNCE: frame = 1 << pos. pos runs 0→WIDTH-1→0; wrap when pos returns to 0, i.e. every 2·WIDTH-2 steps.
  - 4 BLINK: frame alternates PATTERN, 0, PATTERN…; wrap every 2 steps.
  - 5 COUNT: frame = 0, 1, 2…, modulo 2^WIDTH; wrap on 255→0.
  - 6 and 7: behave as STATIC.
- PATTERN writes while running:
  - STATIC and BLINK use the new value at the next step.
  - ROTL and ROTR use it only at the next restart.
- A PERIOD write while running takes effect at the next prescaler compare. The prescaler is not cleared.
- Wrap flag set and software clear in the same cycle: set wins.
- Reset state:
  - FSM in IDLE, prescaler 0, frame 0, wrap flag 0.
  - `led_chipselect`=0, `led_write_n`=1, `led_writedata`=0, `led_address`=0, `readdata` reflects reset register values.

## Timing
- Strobe: `led_chipselect`=1 and `led_write_n`=0 for exactly 1 cycle. `led_writedata` holds the new frame during that cycle and keeps it afterwards.
- Restart written at edge N: strobe carrying step 0 is high during cycle N+1. Later strobes follow every P cycles (N+1+P, N+1+2P, …).
- Prescaler: counts 0..P-1 in RUN. The tick at P-1 advances the frame, and the strobe appears the next cycle.
- P=1: a strobe every cycle, with the frame advancing every cycle.
- STATUS[15:8] updates on the same edge that raises the strobe.
- Disable written at edge N: no strobe starts after edge N. A strobe already raised at edge N completes its one cycle.
- PIO slave has no waitrequest, so no back-pressure handling is required.

## Test plan
- Reset: assert `reset` asynchronously mid-RUN → outputs return to reset values immediately; STATUS reads 0; PATTERN reads 8'h01.
- ROTL with PATTERN=8'h81, PERIOD=4: frames 81, 03, 06, 0C… appear with strobes exactly 4 cycles apart. First strobe is 1 cycle after the CTRL write. Wrap flag sets on the 8th step.
- BOUNCE with PERIOD=1: frames 01, 02, …, 80, 40, …, 01, one per cycle. Wrap flag sets after 14 steps. Writing 1 to STATUS[1] clears it, but set wins if coincident.
- BLINK with PATTERN=8'hA5: frames A5, 00, A5. Writing PATTERN=8'h3C mid-run makes the next non-zero frame 3C.
- COUNT with PERIOD=0: treated as P=1; 255→0 rollover sets wrap.
- Disable written in the same cycle a strobe rises → that strobe lasts exactly 1 cycle; no further strobes; STATUS[0]=0. Re-enable → step-0 frame strobe at N+1.
